ex_mem_stage: RTL and testbench

//   Execute stage plus EX/MEM pipeline register of the 5-stage MIPS pipeline.
//   It consumes the ID/EX latch outputs and decodes ALU control from aluop/funct.
//   It computes the ALU result, zero flag, branch target and destination register.
//   It registers these results, along with pass-through WB/M control, into EX/MEM.

---
 rtl/ex_mem_stage.sv | 127 ++++++++++++
 tb/tb_ex_mem_stage.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// Execute stage and EX/MEM pipeline register: ALU control decode, ALU, branch target and
// destination select. The results are registered with pass-through WB/M control and a valid bit.
module ex_mem_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic              stall,
    input  logic              flush,
    input  logic [1:0]        wb_ctl,
    input  logic [2:0]        m_ctl,
    input  logic              regdst,
    input  logic              alusrc,
    input  logic [1:0]        aluop,
    input  logic [DATA_W-1:0] npc,
    input  logic [DATA_W-1:0] rdata1,
    input  logic [DATA_W-1:0] rdata2,
    input  logic [DATA_W-1:0] s_extend,
    input  logic [REG_W-1:0]  instr_2016,
    input  logic [REG_W-1:0]  instr_1511,
    output logic [1:0]        wb_ctlout,
    output logic [2:0]        m_ctlout,
    output logic [DATA_W-1:0] add_result,
    output logic              zero,
    output logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] rdata2out,
    output logic [REG_W-1:0]  muxout,
    output logic              valid_out
);

    localparam logic [3:0] CtlAnd = 4'b0000;
    localparam logic [3:0] CtlOr  = 4'b0001;
    localparam logic [3:0] CtlAdd = 4'b0010;
    localparam logic [3:0] CtlSub = 4'b0110;
    localparam logic [3:0] CtlSlt = 4'b0111;
    localparam logic [3:0] CtlNop = 4'b1111;

    logic [3:0]        ctl;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_d;
    logic [DATA_W-1:0] target_d;
    logic [REG_W-1:0]  dest_d;

    logic [1:0]        wb_q;
    logic [2:0]        m_q;
    logic [DATA_W-1:0] add_q;
    logic              zero_q;
    logic [DATA_W-1:0] alu_q;
    logic [DATA_W-1:0] rdata2_q;
    logic [REG_W-1:0]  mux_q;
    logic              valid_q;

    always_comb begin
        ctl = CtlNop;
        unique case (aluop)
            2'b00: ctl = CtlAdd;
            2'b01: ctl = CtlSub;
            2'b11: ctl = CtlAdd;
            2'b10: begin
                case (s_extend[5:0])
                    6'b100000: ctl = CtlAdd;
                    6'b100010: ctl = CtlSub;
                    6'b100100: ctl = CtlAnd;
                    6'b100101: ctl = CtlOr;
                    6'b101010: ctl = CtlSlt;
                    default:   ctl = CtlNop;
                endcase
            end
            default: ctl = CtlNop;
        endcase
    end

    always_comb begin
        alu_b = alusrc ? s_extend : rdata2;
        alu_d = '0;
        case (ctl)
            CtlAdd:  alu_d = rdata1 + alu_b;
            CtlSub:  alu_d = rdata1 - alu_b;
            CtlAnd:  alu_d = rdata1 & alu_b;
            CtlOr:   alu_d = rdata1 | alu_b;
            CtlSlt:  alu_d = {{(DATA_W-1){1'b0}}, ($signed(rdata1) < $signed(alu_b))};
            default: alu_d = '0;
        endcase
    end

    assign target_d = npc + {s_extend[DATA_W-3:0], 2'b00};
    assign dest_d   = regdst ? instr_1511 : instr_2016;

    // Flush clears only the control/valid bits; data registers are don't-care behind a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_q     <= '0;
            m_q      <= '0;
            add_q    <= '0;
            zero_q   <= 1'b0;
            alu_q    <= '0;
            rdata2_q <= '0;
            mux_q    <= '0;
            valid_q  <= 1'b0;
        end else if (flush) begin
            wb_q    <= '0;
            m_q     <= '0;
            valid_q <= 1'b0;
        end else if (!stall) begin
            wb_q     <= valid_in ? wb_ctl : 2'b00;
            m_q      <= valid_in ? m_ctl : 3'b000;
            add_q    <= target_d;
            zero_q   <= (alu_d == '0);
            alu_q    <= alu_d;
            rdata2_q <= rdata2;
            mux_q    <= dest_d;
            valid_q  <= valid_in;
        end
    end

    assign wb_ctlout  = wb_q;
    assign m_ctlout   = m_q;
    assign add_result = add_q;
    assign zero       = zero_q;
    assign alu_result = alu_q;
    assign rdata2out  = rdata2_q;
    assign muxout     = mux_q;
    assign valid_out  = valid_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: a reference model pushes expected EX/MEM contents to a
// scoreboard each cycle, and each test task pops and compares after the clock edge.
module tb_ex_mem_stage;

    typedef struct packed {
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [31:0] add;
        logic        zero;
        logic [31:0] alu;
        logic [31:0] rd2;
        logic [4:0]  mux;
        logic        valid;
    } out_t;

    logic        clk = 1'b0;
    logic        rst_n, valid_in, stall, flush, regdst, alusrc;
    logic [1:0]  wb_ctl, aluop;
    logic [2:0]  m_ctl;
    logic [31:0] npc, rdata1, rdata2, s_extend;
    logic [4:0]  instr_2016, instr_1511;
    logic [1:0]  wb_ctlout;
    logic [2:0]  m_ctlout;
    logic [31:0] add_result, alu_result, rdata2out;
    logic        zero, valid_out;
    logic [4:0]  muxout;
    out_t        dut_vec;

    out_t sb_q[$];
    out_t model_q = '0;
    out_t exp;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ex_mem_stage #(.DATA_W(32), .REG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .stall(stall), .flush(flush),
        .wb_ctl(wb_ctl), .m_ctl(m_ctl), .regdst(regdst), .alusrc(alusrc), .aluop(aluop),
        .npc(npc), .rdata1(rdata1), .rdata2(rdata2), .s_extend(s_extend),
        .instr_2016(instr_2016), .instr_1511(instr_1511), .wb_ctlout(wb_ctlout),
        .m_ctlout(m_ctlout), .add_result(add_result), .zero(zero), .alu_result(alu_result),
        .rdata2out(rdata2out), .muxout(muxout), .valid_out(valid_out)
    );

    assign dut_vec = '{wb: wb_ctlout, m: m_ctlout, add: add_result, zero: zero,
                       alu: alu_result, rd2: rdata2out, mux: muxout, valid: valid_out};

    function automatic logic [31:0] ref_alu();
        logic [31:0] b;
        b = alusrc ? s_extend : rdata2;
        if (aluop == 2'b00 || aluop == 2'b11) return rdata1 + b;
        if (aluop == 2'b01) return rdata1 - b;
        case (s_extend[5:0])
            6'h20:   return rdata1 + b;
            6'h22:   return rdata1 - b;
            6'h24:   return rdata1 & b;
            6'h25:   return rdata1 | b;
            6'h2a:   return ($signed(rdata1) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Predict the register contents after the coming edge, queue them, then advance one clock.
    task automatic cycle();
        out_t nxt;
        nxt = model_q;
        if (!rst_n) begin
            nxt = '0;
        end else if (flush) begin
            nxt.valid = 1'b0;
            nxt.wb    = 2'b00;
            nxt.m     = 3'b000;
        end else if (!stall) begin
            nxt.valid = valid_in;
            nxt.wb    = valid_in ? wb_ctl : 2'b00;
            nxt.m     = valid_in ? m_ctl : 3'b000;
            nxt.alu   = ref_alu();
            nxt.zero  = (nxt.alu == 32'd0);
            nxt.add   = npc + (s_extend << 2);
            nxt.rd2   = rdata2;
            nxt.mux   = regdst ? instr_1511 : instr_2016;
        end
        model_q = nxt;
        sb_q.push_back(nxt);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        logic [5:0] functs [6];
        functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h07};
        valid_in   = 1'($urandom);
        wb_ctl     = 2'($urandom);
        m_ctl      = 3'($urandom);
        regdst     = 1'($urandom);
        alusrc     = 1'($urandom);
        aluop      = 2'($urandom);
        npc        = $urandom;
        rdata1     = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
        rdata2     = ($urandom_range(0, 3) == 0) ? rdata1 : $urandom;
        s_extend   = $urandom;
        s_extend[5:0] = functs[$urandom_range(0, 5)];
        instr_2016 = 5'($urandom);
        instr_1511 = 5'($urandom);
    endtask

    task automatic set_idle();
        rand_inputs();
        stall = 1'b0;
        flush = 1'b0;
        valid_in = 1'b1;
        alusrc = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rand_inputs();
            stall = 1'($urandom);
            flush = 1'($urandom);
            cycle();
            exp = sb_q.pop_front();
            checks++;
            if (dut_vec !== exp) begin
                failures++;
                $display("FAIL reset_outputs: got=%h exp=%h", dut_vec, exp);
            end
        end
        checks++;
        if (valid_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid: got=%b exp=0", valid_out);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_rtype_add();
        set_idle();
        aluop = 2'b10; s_extend = 32'h0000_0020; rdata1 = 32'd5; rdata2 = 32'd7;
        regdst = 1'b1; instr_1511 = 5'd9;
        cycle();
        exp = sb_q.pop_front();
        checks++;
        if (dut_vec !== exp) begin
            failures++;
            $display("FAIL rtype_add: got=%h exp=%h", dut_vec, exp);
        end
        checks++;
        if ({alu_result, zero, muxout, valid_out} !== {32'd12, 1'b0, 5'd9, 1'b1}) begin
            failures++;
            $display("FAIL rtype_add_fields: got alu=%h zero=%b mux=%0d valid=%b exp 12/0/9/1",
                     alu_result, zero, muxout, valid_out);
        end
    endtask

    task automatic test_beq();
        set_idle();
        aluop = 2'b01; rdata1 = 32'h1234; rdata2 = 32'h1234; npc = 32'h100; s_extend = 32'd3;
        cycle();
        exp = sb_q.pop_front();
        checks++;
        if (dut_vec !== exp) begin
            failures++;
            $display("FAIL beq: got=%h exp=%h", dut_vec, exp);
        end
        checks++;
        if ({alu_result, zero, add_result} !== {32'd0, 1'b1, 32'h10C}) begin
            failures++;
            $display("FAIL beq_fields: got alu=%h zero=%b target=%h exp 0/1/10c",
                     alu_result, zero, add_result);
        end
    endtask

    task automatic test_slt_lw();
        set_idle();
        aluop = 2'b10; s_extend = 32'h0000_002A; rdata1 = 32'hFFFF_FFFF; rdata2 = 32'd1;
        cycle();
        exp = sb_q.pop_front();
        checks++;
        if (dut_vec !== exp || alu_result !== 32'd1) begin
            failures++;
            $display("FAIL slt_signed: got=%h exp=%h (alu must be 1)", dut_vec, exp);
        end
        set_idle();
        aluop = 2'b00; alusrc = 1'b1; s_extend = 32'hFFFF_FFFC; rdata1 = 32'h10;
        regdst = 1'b0; instr_2016 = 5'd4;
        cycle();
        exp = sb_q.pop_front();
        checks++;
        if (dut_vec !== exp || alu_result !== 32'hC || muxout !== 5'd4) begin
            failures++;
            $display("FAIL lw: got=%h exp=%h (alu must be c, mux 4)", dut_vec, exp);
        end
    endtask

    task automatic test_stall_flush();
        set_idle();
        aluop = 2'b00; rdata1 = 32'd100; rdata2 = 32'd23; wb_ctl = 2'b10; m_ctl = 3'b000;
        cycle();
        exp = sb_q.pop_front();
        checks++;
        if (dut_vec !== exp || alu_result !== 32'd123) begin
            failures++;
            $display("FAIL stall_capture: got=%h exp=%h", dut_vec, exp);
        end
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            stall = 1'b1;
            cycle();
            exp = sb_q.pop_front();
            checks++;
            if (dut_vec !== exp || alu_result !== 32'd123 || valid_out !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold: got=%h exp=%h", dut_vec, exp);
            end
        end
        rand_inputs();
        stall = 1'b1;
        flush = 1'b1;
        cycle();
        exp = sb_q.pop_front();
        checks++;
        if (dut_vec !== exp ||
            {valid_out, wb_ctlout, m_ctlout, alu_result} !== {1'b0, 2'b00, 3'b000, 32'd123}) begin
            failures++;
            $display("FAIL flush_over_stall: got=%h exp=%h", dut_vec, exp);
        end
    endtask

    task automatic test_bubble();
        set_idle();
        valid_in = 1'b0; wb_ctl = 2'b11; m_ctl = 3'b010;
        cycle();
        exp = sb_q.pop_front();
        checks++;
        if (dut_vec !== exp ||
            {valid_out, wb_ctlout, m_ctlout} !== {1'b0, 2'b00, 3'b000}) begin
            failures++;
            $display("FAIL bubble: got=%h exp=%h", dut_vec, exp);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            rand_inputs();
            stall = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 7) == 0);
            cycle();
            exp = sb_q.pop_front();
            checks++;
            if (dut_vec !== exp) begin
                failures++;
                $display("FAIL back_to_back[%0d]: got=%h exp=%h", i, dut_vec, exp);
            end
            checks++;
            if (!valid_out && (wb_ctlout !== 2'b00 || m_ctlout !== 3'b000)) begin
                failures++;
                $display("FAIL bubble_invariant[%0d]: got wb=%b m=%b exp 0/0",
                         i, wb_ctlout, m_ctlout);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rtype_add();
        test_beq();
        test_slt_lw();
        test_stall_flush();
        test_bubble();
        test_back_to_back();
        test_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
